fetch_redirect_unit: RTL and testbench

Fetch-stage front end and the consumer of the execute-stage branch resolution signals. It owns the architectural fetch PC and issues 16-bit Thumb instruction requests to instruction memory. Returned halfwords are buffered in order and handed to decode with a valid/ready handshake. On take-branch/flush it redirects the PC, empties its buffer and discards responses still in flight from the wrong path.

---
 rtl/fetch_redirect_unit_pkg.sv | 24 ++
 rtl/fetch_redirect_unit_fetch_fifo.sv | 50 +++++
 rtl/fetch_redirect_unit.sv | 109 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types for the fetch front end: word width, Thumb halfword width and
// the entry format buffered between instruction memory and decode.
package fetch_redirect_unit_pkg;

    localparam int WORD           = 32;
    localparam int THUMB_INST_W   = 16;
    localparam int PC_READ_OFFSET = 4;

    typedef enum logic {
        NO_BRANCH   = 1'b0,
        TAKE_BRANCH = 1'b1
    } take_branch_ctrl_sig;

    typedef enum logic {
        NO_FLUSH       = 1'b0,
        FLUSH_PIPELINE = 1'b1
    } flush_pipeline_sig;

    typedef struct packed {
        logic [THUMB_INST_W-1:0] instr;
        logic [WORD-1:0]         pc;
    } fetch_entry;

endpackage

// File: rtl/fetch_redirect_unit_fetch_fifo.sv
// In-order instruction buffer between imem responses and decode.
// A single-cycle clear wins over a simultaneous push.
module fetch_fifo
    import fetch_redirect_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry                 din,
    output fetch_entry                 dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the fetch PC, issues halfword requests with credit
// flow control, buffers responses for decode and redirects on taken branches.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [WORD-1:0] RESET_VECTOR    = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  take_branch_ctrl_sig     take_branch_i,
    input  flush_pipeline_sig       flush_pipeline_i,
    input  logic [WORD-1:0]         branch_target_i,
    output logic                    imem_req_o,
    output logic [WORD-1:0]         imem_addr_o,
    input  logic                    imem_ready_i,
    input  logic                    imem_resp_valid_i,
    input  logic [THUMB_INST_W-1:0] imem_resp_data_i,
    input  logic                    decode_ready_i,
    output logic                    is_valid_o,
    output logic [THUMB_INST_W-1:0] instruction_o,
    output logic [WORD-1:0]         program_counter_o
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [WORD-1:0] fetch_pc;
    logic [WORD-1:0] resp_pc;
    logic [WORD-1:0] target_aligned;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_count;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            redirect;
    logic            credit_ok;
    logic            resp_live;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_entry      push_entry;
    fetch_entry      head_entry;

    assign redirect       = (take_branch_i == TAKE_BRANCH);
    assign target_aligned = {branch_target_i[WORD-1:1], 1'b0};

    // Every issued request must already own a buffer slot for its response.
    assign credit_ok  = (int'(outstanding) < MAX_OUTSTANDING) &&
                        ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);
    assign imem_req_o = !reset_i && !redirect && credit_ok;
    assign imem_addr_o = fetch_pc;
    assign accept     = imem_req_o && imem_ready_i;

    assign resp_live  = imem_resp_valid_i && (outstanding != '0);
    assign push       = resp_live && (drop_count == '0) && !redirect;

    assign is_valid_o = !reset_i && !fifo_empty && !redirect &&
                        (flush_pipeline_i != FLUSH_PIPELINE);
    assign pop        = is_valid_o && decode_ready_i;

    assign push_entry.instr = imem_resp_data_i;
    assign push_entry.pc    = resp_pc + WORD'(PC_READ_OFFSET);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(resp_live);
            if (redirect) begin
                // Whatever is still in flight after this cycle belongs to the old path.
                fetch_pc   <= target_aligned;
                resp_pc    <= target_aligned;
                drop_count <= outstanding - OW'(resp_live);
            end else begin
                if (accept) fetch_pc <= fetch_pc + WORD'(2);
                if (resp_live) begin
                    if (drop_count != '0) drop_count <= drop_count - 1'b1;
                    else                  resp_pc    <= resp_pc + WORD'(2);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk_i),
        .reset (reset_i),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instruction_o     = head_entry.instr;
    assign program_counter_o = head_entry.pc;

    resp_without_request: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(imem_resp_valid_i && (outstanding == '0))
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: in-order memory model with random latency,
// path-epoch reference model of the decode stream, directed scenarios plus random run.
module tb_fetch_redirect_unit;
    import fetch_redirect_unit_pkg::*;

    logic                clk = 1'b0;
    logic                reset_i;
    take_branch_ctrl_sig take_branch_i;
    flush_pipeline_sig   flush_pipeline_i;
    logic [31:0]         branch_target_i;
    logic                imem_req_o;
    logic [31:0]         imem_addr_o;
    logic                imem_ready_i;
    logic                imem_resp_valid_i;
    logic [15:0]         imem_resp_data_i;
    logic                decode_ready_i;
    logic                is_valid_o;
    logic [15:0]         instruction_o;
    logic [31:0]         program_counter_o;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .take_branch_i     (take_branch_i),
        .flush_pipeline_i  (flush_pipeline_i),
        .branch_target_i   (branch_target_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .decode_ready_i    (decode_ready_i),
        .is_valid_o        (is_valid_o),
        .instruction_o     (instruction_o),
        .program_counter_o (program_counter_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        mq[$];      // requests accepted by memory, not yet answered
    logic [47:0] exp_q[$];   // {instr, pc+4} the decode stage must still see
    logic [31:0] m_pc;
    int          m_epoch = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rdy_pct = 100, dec_pct = 100, lat_extra = 0, br_pct = 0;
    bit          br_on_resp = 1'b0;
    bit          branched = 1'b0;
    bit          rsp_drv = 1'b0;
    bit          watch = 1'b0;
    logic [31:0] first_pc;
    int          accepts = 0, pops = 0;

    function automatic logic [15:0] mem_data(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_update();
        bit   e_req, e_val;
        int   out, due;
        req_t r;
        if (reset_i) begin
            chk("reset_req", imem_req_o, 1'b0);
            chk("reset_valid", is_valid_o, 1'b0);
            mq.delete();
            exp_q.delete();
            m_pc = 32'h0;
            m_epoch++;
            return;
        end
        out   = mq.size();
        e_req = !branched && (out < 2) && (out + exp_q.size() < 4);
        e_val = (exp_q.size() > 0) && !branched;
        chk("imem_req", imem_req_o, e_req);
        chk("imem_addr", imem_addr_o, m_pc);
        chk("is_valid", is_valid_o, e_val);
        if (e_val && is_valid_o) begin
            chk("instruction", instruction_o, exp_q[0][47:32]);
            chk("program_counter", program_counter_o, exp_q[0][31:0]);
            if (watch) begin
                first_pc = exp_q[0][31:0];
                watch = 1'b0;
            end
        end
        if (e_req && imem_ready_i) accepts++;
        if (e_val && decode_ready_i) pops++;
        if (rsp_drv) r = mq.pop_front();
        if (branched) begin
            exp_q.delete();
            m_epoch++;
            m_pc = {branch_target_i[31:1], 1'b0};
        end else begin
            if (e_val && decode_ready_i) void'(exp_q.pop_front());
            if (rsp_drv && r.epoch == m_epoch)
                exp_q.push_back({mem_data(r.addr), r.addr + 32'd4});
            if (e_req && imem_ready_i) begin
                due = cyc + 1 + $urandom_range(0, lat_extra);
                if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
                mq.push_back('{m_pc, m_epoch, due});
                m_pc = m_pc + 32'd2;
            end
        end
    endtask

    task automatic cycle(input bit br, input logic [31:0] tgt, input bit rst);
        logic [31:0] t;
        bit          br_now;
        @(posedge clk);
        #1;
        reset_i        = rst;
        imem_ready_i   = ($urandom_range(1, 100) <= rdy_pct);
        decode_ready_i = ($urandom_range(1, 100) <= dec_pct);
        rsp_drv        = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        imem_resp_valid_i = rsp_drv;
        imem_resp_data_i  = rsp_drv ? mem_data(mq[0].addr) : 16'($urandom);
        br_now = !rst && (br || ($urandom_range(1, 100) <= br_pct) || (br_on_resp && rsp_drv));
        if (br) t = tgt;
        else if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else t = $urandom;
        branch_target_i = t;
        if (br_now) begin
            take_branch_i    = TAKE_BRANCH;
            flush_pipeline_i = FLUSH_PIPELINE;
        end else begin
            take_branch_i    = NO_BRANCH;
            flush_pipeline_i = NO_FLUSH;
        end
        branched = br_now;
        @(negedge clk);
        check_update();
        cyc++;
    endtask

    task automatic fail_timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        reset_i = 1'b1;
        take_branch_i = NO_BRANCH;
        flush_pipeline_i = NO_FLUSH;
        branch_target_i = '0;
        imem_ready_i = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i = '0;
        decode_ready_i = 1'b0;
        m_pc = 32'h0;
        cycle(0, 0, 1);
        cycle(0, 0, 1);

        // Streaming: one instruction per cycle once the pipe fills.
        pops = 0; watch = 1'b1; first_pc = '1;
        cycle(0, 0, 0);
        chk("t1_first_addr", imem_addr_o, 32'h0);
        chk("t1_first_req", imem_req_o, 1'b1);
        repeat (19) cycle(0, 0, 0);
        chk("t1_pops", pops, 18);
        chk("t1_first_pc", first_pc, 32'h4);

        // Decode stall: credit limits issue to the buffer depth.
        cycle(0, 0, 1);
        dec_pct = 0; accepts = 0;
        repeat (10) cycle(0, 0, 0);
        chk("t2_accepts", accepts, 4);
        chk("t2_req_stalled", imem_req_o, 1'b0);
        dec_pct = 100;
        repeat (10) cycle(0, 0, 0);

        // Redirect with two requests in flight.
        cycle(0, 0, 1);
        lat_extra = 3; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 0, 0);
            if (mq.size() == 2 && m_pc >= 32'h10) found = 1'b1;
        end
        if (!found) fail_timeout("t3_two_outstanding");
        cycle(1, 32'h101, 0);
        watch = 1'b1; first_pc = '1;
        cycle(0, 0, 0);
        chk("t3_target_addr", imem_addr_o, 32'h100);
        repeat (25) cycle(0, 0, 0);
        chk("t3_first_pc", first_pc, 32'h104);

        // Response landing in the redirect cycle.
        lat_extra = 1; br_on_resp = 1'b1; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 0, 0);
            if (branched) found = 1'b1;
        end
        br_on_resp = 1'b0;
        if (!found) fail_timeout("t4_resp_in_redirect");
        else chk("t4_valid_in_redirect", is_valid_o, 1'b0);
        repeat (20) cycle(0, 0, 0);

        // Back-to-back redirects: only the second path survives.
        cycle(1, 32'h200, 0);
        cycle(1, 32'h300, 0);
        watch = 1'b1; first_pc = '1;
        cycle(0, 0, 0);
        chk("t5_target_addr", imem_addr_o, 32'h300);
        repeat (25) cycle(0, 0, 0);
        chk("t5_first_pc", first_pc, 32'h304);

        // Reset in the middle of a stalled, busy pipe.
        dec_pct = 0; lat_extra = 2;
        repeat (6) cycle(0, 0, 0);
        cycle(0, 0, 1);
        dec_pct = 100; lat_extra = 0;
        cycle(0, 0, 0);
        chk("t6_restart_addr", imem_addr_o, 32'h0);
        chk("t6_restart_req", imem_req_o, 1'b1);
        chk("t6_restart_valid", is_valid_o, 1'b0);

        // Random traffic with random redirects, including targets near the wrap.
        rdy_pct = 70; dec_pct = 60; lat_extra = 3; br_pct = 3;
        repeat (3000) cycle(0, 0, 0);
        rdy_pct = 100; dec_pct = 100; br_pct = 0;
        repeat (20) cycle(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
